pc_branch_unit: RTL
===================

Name: pc_branch_unit

Overview:
Fetch-side sequencer that consumes the 8-bit ALU's Zero/Parity/Odd flags and produces the program counter for instruction memory.
- Holds a flag register loaded from the ALU, a writable branch-target lookup table, and a 3-state run-control FSM (IDLE/RUN/HALT).
- Sits directly downstream of the ALU for flags and upstream of instruction fetch/decode, which feeds the ALU's OP and operands.

Parameters:
PC_W, 10, program counter width in bits
LUT_DEPTH, 16, number of branch-target table entries; index width IDX_W = $clog2(LUT_DEPTH)
START_PC, 0, PC value loaded on reset and on every start

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begins or restarts execution at START_PC
halt_req  input  1  current instruction is halt; stop after this cycle
alu_zero  input  1  ALU Zero flag (result == 0)
alu_parity  input  1  ALU Parity flag (XOR reduction of result)
alu_odd  input  1  ALU Odd flag (result LSB)
flag_we  input  1  latch the three ALU flags this cycle
br_en  input  1  current instruction is a conditional branch
br_cond  input  2  00 always, 01 zero, 10 parity, 11 odd
br_inv  input  1  invert the selected condition (ignored for 00)
br_idx  input  IDX_W  LUT entry holding the branch target
lut_we  input  1  write the branch-target table
lut_waddr  input  IDX_W  table write index
lut_wdata  input  PC_W  table write data
pc  output  PC_W  current program counter
running  output  1  FSM in RUN
done  output  1  FSM in HALT
flags_q  output  3  registered flags {odd, parity, zero}
taken  output  1  registered; high the cycle after a taken branch

Behaviour:
- Reset, synchronous and highest priority:
  - state=IDLE, pc=START_PC, flags_q=0, taken=0, running=0, done=0.
  - All LUT entries cleared to 0.
  - Reset asserted mid-RUN overrides every other input that cycle.
- running and done decode directly from state; no extra latency.
- IDLE:
  - pc holds START_PC.
  - br_en, halt_req and flag_we are ignored; lut_we is honoured.
  - start -> RUN; pc stays START_PC, so the first instruction fetched is START_PC.
- RUN, evaluated each cycle in this priority order:
  1. start -> pc=START_PC, stay RUN, taken=0.
  2. halt_req -> HALT; pc frozen (not incremented); taken=0.
  3. br_en and cond true -> pc=lut[br_idx]; taken=1 next cycle.
  4. Otherwise -> pc=pc+1, modulo 2^PC_W (wraps to 0 from all-ones); taken=0.
- Condition evaluation:
  - cond = selected flag from flags_q (not from the live alu_* inputs), XOR br_inv.
  - br_cond=00 is always true; br_inv is ignored for 00.
- Flag register:
  - flag_we loads {alu_odd, alu_parity, alu_zero} into flags_q in RUN only.
  - When flag_we and br_en are asserted in the same cycle, the branch uses the pre-update flags_q; the new flags are visible from the next cycle.
- HALT:
  - pc and flags_q hold; done=1.
  - br_en, halt_req and flag_we are ignored.
  - start -> RUN with pc=START_PC; flags_q is preserved.
- Branch-target LUT:
  - lut_we is honoured in every state except during reset.
  - Reads are combinational.
  - A write and a branch reading the same index in the same cycle: the branch uses the old entry.
  - br_idx >= LUT_DEPTH (non-power-of-2 depth) reads 0; writes to such an index are dropped.
- taken is 0 in IDLE and HALT, and is cleared on any non-branch RUN cycle.

Test Plan:
1. Reset, then start; hold 5 cycles with no branch -> pc sequence 0,0,1,2,3,4; running=1 from the cycle after start.
2. Write lut[3]=0x155; set flags via flag_we with alu_zero=1; next cycle br_en, br_cond=01, br_idx=3 -> pc=0x155 next cycle, taken=1; repeat with br_inv=1 -> pc increments, taken=0.
3. Same-cycle flag_we with alu_odd=1 and br_en, br_cond=11, while flags_q.odd=0 -> branch not taken (old flag used); flags_q=3'b100 the cycle after.
4. Run to pc=0x3FF (PC_W=10) with no branch -> next pc=0x000, no stall.
5. halt_req and br_en (cond true) in the same cycle at pc=0x012 -> pc stays 0x012, done=1, taken=0; further br_en/flag_we ignored; start -> pc=0, running=1, flags_q unchanged.
6. Assert reset mid-RUN at pc=0x020 with br_en active and lut[0]=0x0AA -> next cycle pc=0, state IDLE, flags_q=0, lut[0] reads 0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Fetch-side PC sequencer: flag register, branch-target table and
// IDLE/RUN/HALT run control feeding instruction memory.
module pc_branch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int START_PC  = 0,
  localparam int IDX_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             alu_zero,
  input  logic             alu_parity,
  input  logic             alu_odd,
  input  logic             flag_we,
  input  logic             br_en,
  input  logic [1:0]       br_cond,
  input  logic             br_inv,
  input  logic [IDX_W-1:0] br_idx,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [2:0]       flags_q,
  output logic             taken
);

  localparam int SLOTS = 2 ** IDX_W;
  localparam logic [PC_W-1:0] START = PC_W'(START_PC);
  localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(LUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [2:0] flags_nxt;
  logic taken_nxt;

  logic [PC_W-1:0] lut [SLOTS];
  logic [PC_W-1:0] target;
  logic rd_ok, wr_ok, cond;

  // Indices past a non-power-of-2 depth read as 0 and drop writes.
  assign rd_ok  = {1'b0, br_idx} < DEPTH;
  assign wr_ok  = {1'b0, lut_waddr} < DEPTH;
  assign target = rd_ok ? lut[br_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) lut[i] <= '0;
    end else if (lut_we && wr_ok) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    cond = 1'b1;
    unique case (br_cond)
      2'b00: cond = 1'b1;
      2'b01: cond = flags_q[0] ^ br_inv;
      2'b10: cond = flags_q[1] ^ br_inv;
      2'b11: cond = flags_q[2] ^ br_inv;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flags_nxt = flags_q;
    taken_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        pc_nxt = START;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // Branch decision below still sees the pre-update flags.
        if (flag_we) flags_nxt = {alu_odd, alu_parity, alu_zero};
        if (start) begin
          pc_nxt = START;
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (br_en && cond) begin
          pc_nxt    = target;
          taken_nxt = 1'b1;
        end else begin
          pc_nxt = pc + 1'b1;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= START;
      flags_q <= '0;
      taken   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      flags_q <= flags_nxt;
      taken   <= taken_nxt;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == HALT);

endmodule
